rgb_lcd_timing_gen: RTL
=======================

// Module: rgb_lcd_timing_gen
// PURPOSE
//  Parametrised RGB-LCD timing generator and FIFO pixel pump; successor of the fixed 800x480 generator.
//  Generates HSYNC/VSYNC/DE from per-axis sync/back-porch/active/front-porch params, prefetches RGB565 from the
//  line FIFO and drives expanded RGB888. Adds frame-request gating, free-run mode, sync polarity, underflow fill/flag.
//  Sits between the i8080 write-side FIFO and the panel pins; CLK is the pixel clock.
// PARAMETERS
//  H_SYNC 48 | H_BP 88 | H_ACTIVE 800 | H_FP 40 : horizontal region lengths in pixels, all >=1
//  V_SYNC 3  | V_BP 32 | V_ACTIVE 480 | V_FP 13 : vertical region lengths in lines, all >=1
//  CNT_W 12        : H/V counter width; must hold H_TOTAL-1 and V_TOTAL-1
//  HS_POL 0, VS_POL 0 : active level of HSYNC/VSYNC; DE is always active-high
//  FREE_RUN 0      : 1 = ignore FRAME_REQ, frames back-to-back from reset release
//  RST_PER_LINE 0  : 1 = FIFO_RST pulsed at start of every line, 0 = at start of frame only
//  FIFO_RST_LEN 20 : FIFO_RST pulse length in cycles, 1..H_SYNC+H_BP-2
//  FILL_RGB 24'hFF0000 : colour driven on an active pixel when FIFO was empty
// PORTS
//  CLK         in  1   pixel clock, single clock domain
//  RST         in  1   synchronous reset, active-high
//  FRAME_REQ   in  1   level; high = producer has a frame, start/continue scanning
//  FIFO_Empty  in  1   FIFO empty flag
//  FIFO_Data   in  16  RGB565, valid the cycle after FIFO_RE (1-cycle read latency)
//  FIFO_RE     out 1   FIFO read enable
//  FIFO_RST    out 1   FIFO reset pulse, active-high
//  LCD_HSYNC/LCD_VSYNC out 1 syncs at HS_POL/VS_POL;  LCD_DE out 1 data enable
//  LCD_R/LCD_G/LCD_B   out 8 each, pixel colour
//  FRAME_START out 1   1-cycle pulse when first pixel of a frame reaches pins
//  UNDERFLOW   out 1   sticky: >=1 fill pixel this frame; cleared with FRAME_START
// BEHAVIOUR
//  - H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; same for V. Region order per axis: SYNC, BP, ACTIVE, FP, from count 0.
//  - FSM IDLE/RUN. IDLE: h_cnt=v_cnt=0, held. IDLE->RUN when FRAME_REQ=1 (or FREE_RUN); h=v=0 next cycle.
//  - RUN: h_cnt++ each cycle; at H_TOTAL-1 wraps to 0, v_cnt++; at frame end (h,v both last) v wraps to 0 and
//    FSM stays RUN if FRAME_REQ=1 (or FREE_RUN) that cycle, else IDLE. FRAME_REQ fall mid-frame: frame completes.
//  - Stage0 (counters): act = h,v in ACTIVE region; FIFO_RE = act & !FIFO_Empty (comb. from counters + flag).
//  - Stage1: register act, rd=FIFO_RE, hs, vs. Stage2: register pins; FIFO_Data captured when stage1 rd=1.
//  - Pin latency: counter value -> HSYNC/VSYNC/DE/RGB = 2 cycles; all pins mutually aligned.
//  - Colour by bit replication: R={d[15:11],d[15:13]}, G={d[10:5],d[10:9]}, B={d[4:0],d[4:2]}.
//  - DE=1 & rd=0 -> RGB=FILL_RGB, UNDERFLOW<=1; no catch-up read later, pixel lost. DE=0 -> RGB=0.
//  - FRAME_START same cycle as first DE of frame; UNDERFLOW set by a fill pixel that cycle wins over clear.
//  - FIFO_RST=1 for h_cnt<FIFO_RST_LEN on v_cnt==0 (every line if RST_PER_LINE); never while act; 0 in IDLE.
//  - IDLE: syncs at inactive level, DE=0, RGB=0, FIFO_RE=0; pipeline drains 2 cycles after frame end.
//  - RST (any time, incl. mid-line): FSM=IDLE, counters 0, pipe cleared; next edge pins are HSYNC=!HS_POL,
//    VSYNC=!VS_POL, DE=0, RGB=0, FIFO_RE=0, FIFO_RST=0, FRAME_START=0, UNDERFLOW=0.
//  - Counter arithmetic in CNT_W bits, no wrap beyond TOTAL-1; elaboration $error if CNT_W too small.
// STRUCTURE
//  - Package rgb_lcd_pkg: rgb565_to_888() function, default 800x480 timing localparams, FSM state enum.
//  - Sub-module lcd_axis_cnt (x2, H and V): count/enable/wrap, outputs sync_n/active/last decodes.
//  - Top: FSM, FIFO_RE/FIFO_RST decode, 2-stage align pipe, colour/fill mux, flags.
// TESTING (small config: H 2/1/4/1 => H_TOTAL 8; V 1/1/3/1 => V_TOTAL 6; FIFO_RST_LEN 1)
//  1 FRAME_REQ=1, FIFO never empty, data ramp 0x0001.. -> 12 DE cycles/frame, 4 per line, pixel n = rgb565_to_888(n),
//    HSYNC low 2 of 8 cycles, VSYNC low 8 cycles, FRAME_START once per 48 cycles.
//  2 Data 0xF800/0x07E0/0x001F/0xFFFF -> RGB FF0000/00FF00/0000FF/FFFFFF exactly.
//  3 FIFO_Empty=1 for pixel 2 of line 0 -> no FIFO_RE that cycle, RGB=FF0000, UNDERFLOW=1 until next FRAME_START.
//  4 FRAME_REQ dropped mid-frame -> frame finishes, then IDLE: DE=0, syncs inactive; reassert -> restart at h=v=0.
//  5 RST pulsed mid-active line -> next cycle all outputs at reset values; FREE_RUN=1 restarts without FRAME_REQ.
//  6 RST_PER_LINE=1 -> FIFO_RST=1 on h_cnt=0 of each of 6 lines, never coincident with FIFO_RE.

Source files
------------

// File: rtl/rgb_lcd_pkg.sv
// Shared definitions for the RGB-LCD timing generator.
//   - Default 800x480 panel timing (pixels / lines per region).
//   - FSM state encoding.
//   - rgb565_to_888(): widens RGB565 to RGB888 by repeating the MSBs of each
//     channel into its LSBs, so full-scale stays full-scale and zero stays zero.
package rgb_lcd_pkg;

  localparam int unsigned DEF_H_SYNC   = 48;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 32;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lcd_state_e;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One scan axis (horizontal or vertical) of the LCD timing generator.
// The count runs SYNC, BP, ACTIVE, FP starting from 0 and wraps after TOTAL-1.
// Ports:
//   i_clk      pixel clock
//   i_rst      synchronous reset, active-high
//   i_clr      hold the count at 0 (scanner idle)
//   i_en       advance the count by one this cycle
//   o_cnt      current position on the axis
//   o_sync     position lies in the sync region
//   o_active   position lies in the active region
//   o_last     position is TOTAL-1 (wraps on the next enabled cycle)
module lcd_axis_cnt
  import rgb_lcd_pkg::*;
#(
  parameter int unsigned SYNC   = 1,
  parameter int unsigned BP     = 1,
  parameter int unsigned ACTIVE = 1,
  parameter int unsigned FP     = 1,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sync,
  output logic             o_active,
  output logic             o_last
);

  localparam int unsigned TOTAL = SYNC + BP + ACTIVE + FP;

  if (SYNC < 1 || BP < 1 || ACTIVE < 1 || FP < 1) begin : g_region_chk
    $error("lcd_axis_cnt: every region length must be at least 1");
  end
  if (TOTAL > (2 ** CNT_W)) begin : g_width_chk
    $error("lcd_axis_cnt: CNT_W too small to hold TOTAL-1");
  end

  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
  // FP >= 1, so the exclusive end of ACTIVE is at most TOTAL-1 and fits
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BP + ACTIVE);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_sync   = (r_cnt < SYNC_END);
  assign o_active = (r_cnt >= ACT_START) && (r_cnt < ACT_END);
  assign o_last   = (r_cnt == LAST);

endmodule

// File: rtl/rgb_lcd_timing_gen.sv
// RGB-LCD timing generator and FIFO pixel pump (pixel-clock domain).
// Generates HSYNC/VSYNC/DE, reads RGB565 from the line FIFO one cycle ahead of
// use and drives RGB888 to the panel. All pins are registered and mutually
// aligned two cycles after the counter position that produced them.
// Ports:
//   i_clk, i_rst            pixel clock, synchronous active-high reset
//   i_frame_req             producer has a frame ready (level)
//   i_fifo_empty            FIFO empty flag
//   i_fifo_data             RGB565 word, valid the cycle after o_fifo_re
//   o_fifo_re               FIFO read enable
//   o_fifo_rst              FIFO reset pulse at start of frame (or line)
//   o_lcd_hsync/o_lcd_vsync syncs, active level HS_POL/VS_POL
//   o_lcd_de                data enable, active-high
//   o_lcd_r/o_lcd_g/o_lcd_b pixel colour
//   o_frame_start           one-cycle pulse with the first DE of a frame
//   o_underflow             sticky: a fill pixel was shown this frame
//
// state   | meaning
// IDLE    | counters held at 0, pins idle, waiting for a frame request
// RUN     | scanning; a frame always completes once started
module rgb_lcd_timing_gen
  import rgb_lcd_pkg::*;
#(
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned CNT_W        = 12,
  parameter bit          HS_POL       = 1'b0,
  parameter bit          VS_POL       = 1'b0,
  parameter bit          FREE_RUN     = 1'b0,
  parameter bit          RST_PER_LINE = 1'b0,
  parameter int unsigned FIFO_RST_LEN = 20,
  parameter logic [23:0] FILL_RGB     = 24'hFF0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_req,
  input  logic        i_fifo_empty,
  input  logic [15:0] i_fifo_data,
  output logic        o_fifo_re,
  output logic        o_fifo_rst,
  output logic        o_lcd_hsync,
  output logic        o_lcd_vsync,
  output logic        o_lcd_de,
  output logic [7:0]  o_lcd_r,
  output logic [7:0]  o_lcd_g,
  output logic [7:0]  o_lcd_b,
  output logic        o_frame_start,
  output logic        o_underflow
);

  // The FIFO reset pulse must end before the first active pixel of the line
  if (FIFO_RST_LEN < 1 || FIFO_RST_LEN + 2 > H_SYNC + H_BP) begin : g_rst_len_chk
    $error("rgb_lcd_timing_gen: FIFO_RST_LEN must be 1..H_SYNC+H_BP-2");
  end

  localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(FIFO_RST_LEN);
  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_SYNC + V_BP);

  lcd_state_e       r_state;
  lcd_state_e       w_state_nxt;
  logic             w_run;
  logic             w_go;

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_sync, w_h_act, w_h_last;
  logic             w_v_sync, w_v_act, w_v_last;

  logic             w_act;
  logic             w_first;

  logic             r_s1_act, r_s1_rd, r_s1_hs, r_s1_vs, r_s1_first;
  logic             r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs, r_s2_uf;
  logic [23:0]      r_s2_rgb;

  assign w_go  = i_frame_req | FREE_RUN;
  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_h_last && w_v_last && !w_go) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  lcd_axis_cnt #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
  ) u_h_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!w_run),
    .i_en     (w_run),
    .o_cnt    (w_h_cnt),
    .o_sync   (w_h_sync),
    .o_active (w_h_act),
    .o_last   (w_h_last)
  );

  lcd_axis_cnt #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
  ) u_v_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!w_run),
    .i_en     (w_run && w_h_last),
    .o_cnt    (w_v_cnt),
    .o_sync   (w_v_sync),
    .o_active (w_v_act),
    .o_last   (w_v_last)
  );

  // Stage 0: decodes straight off the counters. Reading here lets the
  // 1-cycle FIFO latency line up with the stage-2 pin register.
  assign w_act      = w_run && w_h_act && w_v_act;
  assign w_first    = w_act && (w_h_cnt == H_FIRST) && (w_v_cnt == V_FIRST);
  assign o_fifo_re  = w_act && !i_fifo_empty;
  assign o_fifo_rst = w_run && (w_h_cnt < RST_LEN) && (RST_PER_LINE || (w_v_cnt == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_act   <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_first <= 1'b0;
      r_s2_de    <= 1'b0;
      r_s2_hs    <= 1'b0;
      r_s2_vs    <= 1'b0;
      r_s2_fs    <= 1'b0;
      r_s2_uf    <= 1'b0;
      r_s2_rgb   <= '0;
    end else begin
      r_s1_act   <= w_act;
      r_s1_rd    <= o_fifo_re;
      r_s1_hs    <= w_run && w_h_sync;
      r_s1_vs    <= w_run && w_v_sync;
      r_s1_first <= w_first;

      r_s2_de <= r_s1_act;
      r_s2_hs <= r_s1_hs;
      r_s2_vs <= r_s1_vs;
      r_s2_fs <= r_s1_first;

      // An empty FIFO costs the pixel; it is never read back later
      if (r_s1_act) begin
        r_s2_rgb <= r_s1_rd ? rgb565_to_888(i_fifo_data) : FILL_RGB;
      end else begin
        r_s2_rgb <= '0;
      end

      // A fill on the first pixel must leave the flag set, so set beats clear
      if (r_s1_act && !r_s1_rd) begin
        r_s2_uf <= 1'b1;
      end else if (r_s1_first) begin
        r_s2_uf <= 1'b0;
      end
    end
  end

  assign o_lcd_hsync   = r_s2_hs ? HS_POL : ~HS_POL;
  assign o_lcd_vsync   = r_s2_vs ? VS_POL : ~VS_POL;
  assign o_lcd_de      = r_s2_de;
  assign o_lcd_r       = r_s2_rgb[23:16];
  assign o_lcd_g       = r_s2_rgb[15:8];
  assign o_lcd_b       = r_s2_rgb[7:0];
  assign o_frame_start = r_s2_fs;
  assign o_underflow   = r_s2_uf;

endmodule
